// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and iteration count.
package mdu_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding HI/LO.
// Optional macro MDU_EARLY_OUT_EN skips CALC for trivially known results.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [1:0]       hl_w,
   output state_t           dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE; busy covers
   // CALC and FIX; done/hl_w pulse for exactly the DONE cycle with hi/lo valid.
   state_t state, state_next;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               is_div, neg_lo, neg_hi, div0;

   logic               signed_op, sa, sb, quick;
   logic [WIDTH-1:0]   ma, mb;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] step_acc, quick_acc, mul_res;

   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      sa        = signed_op & a[WIDTH-1];
      sb        = signed_op & b[WIDTH-1];
      ma        = sa ? -a : a;
      mb        = sb ? -b : b;
      quick     = 1'b0;
      quick_acc = '0;
`ifdef MDU_EARLY_OUT_EN
      if (!op[1] && (a == '0 || b == '0)) begin
         quick = 1'b1;
      end else if (op[1] && a == '0 && b != '0) begin
         quick = 1'b1;
      end else if (op == OP_DIVU && b != '0 && a < b) begin
         quick     = 1'b1;
         quick_acc = {a, {WIDTH{1'b0}}};
      end
`endif
   end

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      diff    = {1'b0, rem_sh} - {2'b00, opnd};
      if (!is_div)
         step_acc = {mul_sum, acc[WIDTH-1:1]};
      else if (!diff[WIDTH+1])
         step_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         step_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      mul_res = neg_lo ? -acc : acc;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start)
                  state_next = ((op[1] && b == '0) || quick) ? FIX : CALC;
         CALC: if (cnt == CNT_W'(ITER - 1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         div0   <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (start) begin
               cnt    <= '0;
               is_div <= op[1];
               neg_lo <= signed_op & (sa ^ sb);
               neg_hi <= op[1] ? (op == OP_DIV) & sa : signed_op & (sa ^ sb);
               div0   <= op[1] && b == '0;
               opnd   <= op[1] ? mb : ma;
               if (op[1] && b == '0)
                  acc <= {a, {WIDTH{1'b0}}};
               else if (quick)
                  acc <= quick_acc;
               else
                  acc <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
            end
            CALC: begin
               acc <= step_acc;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               // Divide by zero leaves the raw dividend in HI.
               if (div0) begin
                  hi_out <= acc[2*WIDTH-1:WIDTH];
                  lo_out <= '1;
               end else if (!is_div) begin
                  hi_out <= mul_res[2*WIDTH-1:WIDTH];
                  lo_out <= mul_res[WIDTH-1:0];
               end else begin
                  hi_out <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                  lo_out <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state == CALC) || (state == FIX);
   assign done      = (state == DONE);
   assign hl_w      = done ? 2'b11 : 2'b00;
   assign dbg_state = state;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, start filtering
// and mid-operation reset.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] hi_out, lo_out;
   logic [1:0]  hl_w;
   state_t      dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_q[$];

`ifdef MDU_EARLY_OUT_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 34;
`endif

   mdu_iter dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
      .hl_w(hl_w), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      else
         n_pass++;
   endtask

   // Issues one op (cycle 0 = start cycle), optionally re-pulses start at
   // cycle 5, then checks latency, HI/LO and the single-cycle write enable.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int exp_lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit repulse);
      int lat;
      logic [63:0] exp;
      exp_q.push_back({ehi, elo});
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      lat = 1;
      check({tag, "_busy1"}, {63'b0, busy}, 64'd1);
      while (!done && lat < 100) begin
         if (repulse && lat == 5) begin
            start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      exp = exp_q.pop_front();
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_hilo"}, {hi_out, lo_out}, exp);
      check({tag, "_hlw"}, {62'b0, hl_w}, 64'd3);
      @(negedge clk);
      check({tag, "_hlw_off"}, {62'b0, hl_w, busy, done}, 64'd0);
   endtask

   initial begin
      int seen;
      @(negedge clk);
      @(negedge clk);
      check("rst_outs", {busy, done, hl_w, hi_out, lo_out}, 68'd0);
      check("rst_state", {62'b0, dbg_state}, {62'b0, IDLE});
      rst = 1'b0;

      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 0);
      run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        34, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 0);
      run_op("multu_12",  OP_MULTU, 32'h00010000, 32'h00030000, 34, 32'h00000003, 32'h00000000, 0);
      run_op("divu_100",  OP_DIVU,  32'd100,      32'd7,        34, 32'd2,        32'd14,       0);
      run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("div_wrap",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 0);
      run_op("div_nb",    OP_DIV,   32'd20,       32'hFFFFFFFA, 34, 32'd2,        32'hFFFFFFFD, 0);
      run_op("divu_z",    OP_DIVU,  32'd5,        32'd0,        2,  32'd5,        32'hFFFFFFFF, 0);
      run_op("div_z",     OP_DIV,   32'hFFFFFFF7, 32'd0,        2,  32'hFFFFFFF7, 32'hFFFFFFFF, 0);
      run_op("mult_zero", OP_MULT,  32'd0,        32'hDEADBEEF, ZERO_LAT, 32'd0,    32'd0,        0);
      run_op("repulse",   OP_MULTU, 32'd6,        32'd7,        34, 32'd0,        32'd42,       1);

      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("repulse_dropped", 64'(seen), 64'd0);

      // Reset asserted in cycle 10 of a multiply.
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'h12345678;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid", {busy, done, hl_w, hi_out, lo_out}, 68'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || hl_w != 2'b00 || busy) seen++;
      end
      check("rst_no_done", 64'(seen), 64'd0);
      check("rst_hilo", {hi_out, lo_out}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
